mdio_master_ctrl: RTL and testbench

Parametrised MDIO management master; successor to the fixed 32-bit serializer. Accepts one management command per valid/ready handshake. Generates a gated MDC with a programmable divider and an optional preamble, and serialises Clause 22 or Clause 45 frames. For read opcodes it releases MDIO at turnaround, captures 16 data bits, flags a missing-PHY turnaround, and returns the data with a one-cycle valid pulse.

---
 rtl/mdio_pkg.sv | 38 +++
 rtl/mdc_gen.sv | 43 ++++
 rtl/mdio_master_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_mdio_master_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdio_pkg.sv
// Shared MDIO frame constants, FSM state type and command decode helpers.
package mdio_pkg;

  localparam logic [1:0] ST_C22       = 2'b01;
  localparam logic [1:0] ST_C45       = 2'b00;
  localparam logic [1:0] OP_C22_WR    = 2'b01;
  localparam logic [1:0] OP_C22_RD    = 2'b10;
  localparam logic [1:0] OP_C45_ADDR  = 2'b00;
  localparam logic [1:0] OP_C45_WR    = 2'b01;
  localparam logic [1:0] OP_C45_RDINC = 2'b10;
  localparam logic [1:0] OP_C45_RD    = 2'b11;
  localparam logic [1:0] TA_WR        = 2'b10;
  localparam int         HDR_BITS     = 14;
  localparam int         DATA_BITS    = 16;

  typedef enum logic [2:0] {IDLE, PRE, HDR, TA, DATA, REL} state_e;

  function automatic logic cmd_legal(input logic [1:0] st, input logic [1:0] op,
                                     input logic c45_ok);
    if (st == ST_C22) return (op == OP_C22_WR) || (op == OP_C22_RD);
    if (st == ST_C45)
      return c45_ok && (op inside {OP_C45_ADDR, OP_C45_WR, OP_C45_RDINC, OP_C45_RD});
    return 1'b0;
  endfunction

  function automatic logic is_read_op(input logic [1:0] st, input logic [1:0] op);
    if (st == ST_C22) return op == OP_C22_RD;
    return (op == OP_C45_RDINC) || (op == OP_C45_RD);
  endfunction

  // Everything after the preamble, MSB first; TA/data are ignored for reads.
  function automatic logic [31:0] frame_word(input logic [1:0] st, input logic [1:0] op,
                                             input logic [4:0] phyad, input logic [4:0] regad,
                                             input logic [15:0] wdata);
    return {st, op, phyad, regad, TA_WR, wdata};
  endfunction

endpackage

// File: rtl/mdc_gen.sv
// MDC phase generator: low for the first half of each bit, high for the rest.
// bit_start/sample flag the cycle whose closing edge drops/raises MDC.
module mdc_gen #(
  parameter int MDC_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic mdc_en,
  output logic mdc,
  output logic bit_start,
  output logic sample
);
  import mdio_pkg::*;

  localparam int            PW   = $clog2(MDC_DIV);
  localparam logic [PW-1:0] LAST = PW'(MDC_DIV - 1);
  localparam logic [PW-1:0] HALF = PW'(MDC_DIV / 2);

  logic [PW-1:0] phase_q, phase_d;
  logic          mdc_q, mdc_d;

  always_comb begin
    phase_d = '0;
    if (en) phase_d = (phase_q == LAST) ? '0 : phase_q + 1'b1;
    mdc_d = en && mdc_en && (phase_d >= HALF);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= '0;
      mdc_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      mdc_q   <= mdc_d;
    end
  end

  assign mdc       = mdc_q;
  assign bit_start = en && (phase_q == LAST);
  assign sample    = en && (phase_q == HALF - 1'b1);

endmodule

// File: rtl/mdio_master_ctrl.sv
// MDIO management master: one command per handshake, Clause 22/45 framing on
// a gated MDC, read data captured on MDC rise and returned with a valid pulse.
module mdio_master_ctrl #(
  parameter int MDC_DIV     = 4,
  parameter int PRE_LEN     = 32,
  parameter bit SUPPORT_C45 = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_st,
  input  logic [1:0]  cmd_op,
  input  logic [4:0]  cmd_phyad,
  input  logic [4:0]  cmd_regad,
  input  logic [15:0] cmd_wdata,
  output logic        busy,
  output logic        cmd_err,
  output logic        mdc,
  output logic        mdio_out,
  output logic        mdio_oe,
  input  logic        mdio_in,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  output logic        rd_err
);
  import mdio_pkg::*;

  localparam logic [5:0] PRE_LAST  = 6'((PRE_LEN > 0) ? PRE_LEN - 1 : 0);
  localparam logic [5:0] HDR_LAST  = 6'(HDR_BITS - 1);
  localparam logic [5:0] DATA_LAST = 6'(DATA_BITS - 1);

  state_e      state_q, state_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic [31:0] tx_q, tx_d;
  logic [15:0] rx_q, rx_d;
  logic        rd_q, rd_d;
  logic        mdio_out_q, mdio_out_d;
  logic        oe_q, oe_d;
  logic        busy_q, busy_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        cmd_err_q, cmd_err_d;
  logic        ta_err_q, ta_err_d;
  logic [15:0] rd_data_q, rd_data_d;
  logic        rd_valid_q, rd_valid_d;
  logic        rd_err_q, rd_err_d;

  logic        accept, bit_start, sample, gen_en, gen_mdc_en;
  logic [31:0] in_frame;

  assign gen_en     = (state_q != IDLE);
  assign gen_mdc_en = (state_q != REL);

  mdc_gen #(.MDC_DIV(MDC_DIV)) u_mdc_gen (
    .clk       (clk),
    .reset     (reset),
    .en        (gen_en),
    .mdc_en    (gen_mdc_en),
    .mdc       (mdc),
    .bit_start (bit_start),
    .sample    (sample)
  );

  assign accept   = cmd_valid && cmd_ready_q;
  assign in_frame = frame_word(cmd_st, cmd_op, cmd_phyad, cmd_regad, cmd_wdata);

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    rd_d       = rd_q;
    mdio_out_d = mdio_out_q;
    oe_d       = oe_q;
    ta_err_d   = ta_err_q;
    rd_data_d  = rd_data_q;
    rd_err_d   = rd_err_q;
    rd_valid_d = 1'b0;
    cmd_err_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!cmd_legal(cmd_st, cmd_op, SUPPORT_C45)) begin
            cmd_err_d = 1'b1;
          end else begin
            rd_d      = is_read_op(cmd_st, cmd_op);
            bit_cnt_d = '0;
            oe_d      = 1'b1;
            if (PRE_LEN == 0) begin
              state_d    = HDR;
              mdio_out_d = in_frame[31];
              tx_d       = in_frame << 1;
            end else begin
              state_d    = PRE;
              mdio_out_d = 1'b1;
              tx_d       = in_frame;
            end
          end
        end
      end
      PRE: begin
        if (bit_start) begin
          bit_cnt_d = bit_cnt_q + 6'd1;
          if (bit_cnt_q == PRE_LAST) begin
            state_d    = HDR;
            bit_cnt_d  = '0;
            mdio_out_d = tx_q[31];
            tx_d       = tx_q << 1;
          end
        end
      end
      HDR, TA, DATA: begin
        if (bit_start) begin
          tx_d      = tx_q << 1;
          bit_cnt_d = bit_cnt_q + 6'd1;
          if (state_q == HDR && bit_cnt_q == HDR_LAST) begin
            state_d = TA; bit_cnt_d = '0;
          end else if (state_q == TA && bit_cnt_q == 6'd1) begin
            state_d = DATA; bit_cnt_d = '0;
          end else if (state_q == DATA && bit_cnt_q == DATA_LAST) begin
            state_d = REL; bit_cnt_d = '0;
          end
          // Reads hand the line to the PHY from the first turnaround bit on.
          if (state_d == REL || (rd_q && state_d != HDR)) begin
            mdio_out_d = 1'b1;
            oe_d       = 1'b0;
          end else begin
            mdio_out_d = tx_q[31];
          end
          if (state_d == REL && rd_q) begin
            rd_data_d  = rx_q;
            rd_err_d   = ta_err_q;
            rd_valid_d = 1'b1;
          end
        end
        if (sample && rd_q) begin
          if (state_q == TA && bit_cnt_q == 6'd1) ta_err_d = mdio_in;
          if (state_q == DATA) rx_d = {rx_q[14:0], mdio_in};
        end
      end
      REL: begin
        if (bit_start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d      = (state_d != IDLE);
    cmd_ready_d = (state_d == IDLE) && !accept;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      mdio_out_q  <= 1'b1;
      oe_q        <= 1'b0;
      busy_q      <= 1'b0;
      cmd_ready_q <= 1'b0;
      cmd_err_q   <= 1'b0;
      ta_err_q    <= 1'b0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      rd_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      mdio_out_q  <= mdio_out_d;
      oe_q        <= oe_d;
      busy_q      <= busy_d;
      cmd_ready_q <= cmd_ready_d;
      cmd_err_q   <= cmd_err_d;
      ta_err_q    <= ta_err_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      rd_err_q    <= rd_err_d;
    end
    tx_q <= tx_d;
    rx_q <= rx_d;
    rd_q <= rd_d;
  end

  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign cmd_err   = cmd_err_q;
  assign mdio_out  = mdio_out_q;
  assign mdio_oe   = oe_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign rd_err    = rd_err_q;

endmodule

// File: tb/tb_mdio_master_ctrl.sv
// Directed bench: dut_a runs MDC_DIV=4/PRE_LEN=32, dut_b runs MDC_DIV=2/PRE_LEN=0.
`timescale 1ns/1ps
module tb_mdio_master_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset = 1'b1;

  logic        a_cmd_valid = 1'b0, a_cmd_ready;
  logic [1:0]  a_cmd_st = 2'b01, a_cmd_op = 2'b01;
  logic [4:0]  a_cmd_phyad = '0, a_cmd_regad = '0;
  logic [15:0] a_cmd_wdata = '0;
  logic        a_busy, a_cmd_err, a_mdc, a_mdio_out, a_mdio_oe, a_mdio_in = 1'b1;
  logic [15:0] a_rd_data;
  logic        a_rd_valid, a_rd_err;

  logic        b_cmd_valid = 1'b0, b_cmd_ready;
  logic [1:0]  b_cmd_st = 2'b00, b_cmd_op = 2'b00;
  logic [4:0]  b_cmd_phyad = '0, b_cmd_regad = '0;
  logic [15:0] b_cmd_wdata = '0;
  logic        b_busy, b_cmd_err, b_mdc, b_mdio_out, b_mdio_oe, b_mdio_in = 1'b1;
  logic [15:0] b_rd_data;
  logic        b_rd_valid, b_rd_err;

  int tests = 0;
  int fails = 0;

  mdio_master_ctrl #(.MDC_DIV(4), .PRE_LEN(32), .SUPPORT_C45(1'b1)) dut_a (
    .clk(clk), .reset(reset), .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready),
    .cmd_st(a_cmd_st), .cmd_op(a_cmd_op), .cmd_phyad(a_cmd_phyad), .cmd_regad(a_cmd_regad),
    .cmd_wdata(a_cmd_wdata), .busy(a_busy), .cmd_err(a_cmd_err), .mdc(a_mdc),
    .mdio_out(a_mdio_out), .mdio_oe(a_mdio_oe), .mdio_in(a_mdio_in),
    .rd_data(a_rd_data), .rd_valid(a_rd_valid), .rd_err(a_rd_err));

  mdio_master_ctrl #(.MDC_DIV(2), .PRE_LEN(0), .SUPPORT_C45(1'b1)) dut_b (
    .clk(clk), .reset(reset), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
    .cmd_st(b_cmd_st), .cmd_op(b_cmd_op), .cmd_phyad(b_cmd_phyad), .cmd_regad(b_cmd_regad),
    .cmd_wdata(b_cmd_wdata), .busy(b_busy), .cmd_err(b_cmd_err), .mdc(b_mdc),
    .mdio_out(b_mdio_out), .mdio_oe(b_mdio_oe), .mdio_in(b_mdio_in),
    .rd_data(b_rd_data), .rd_valid(b_rd_valid), .rd_err(b_rd_err));

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Waits (bounded) for cmd_ready, presents one command for one edge, then scrambles inputs.
  task automatic issue_a(input logic [1:0] st, input logic [1:0] op, input logic [4:0] phy,
                         input logic [4:0] regad, input logic [15:0] wd);
    int k = 0;
    while (a_cmd_ready !== 1'b1 && k < 400) begin tick(); k++; end
    tests++;
    if (a_cmd_ready !== 1'b1) begin
      fails++; $display("FAIL issue_ready got %b want 1", a_cmd_ready);
    end
    a_cmd_valid = 1'b1; a_cmd_st = st; a_cmd_op = op;
    a_cmd_phyad = phy; a_cmd_regad = regad; a_cmd_wdata = wd;
    tick();
    a_cmd_valid = 1'b0; a_cmd_phyad = ~phy; a_cmd_regad = ~regad; a_cmd_wdata = ~wd;
  endtask

  // Walks one dut_a frame from the cycle after acceptance to the first idle cycle.
  task automatic drive_frame_a(input logic [63:0] line, input int oe_bits, input logic rd,
                               input logic ta1, input logic [15:0] word, input string tag);
    for (int n = 0; n <= 260; n++) begin
      int b;
      logic [5:0] exp, act;
      b = n / 4;
      if (b < 64)
        exp = {(n % 4) >= 2, b < oe_bits, (b < oe_bits) ? line[63-b] : 1'b1, 1'b1, 1'b0, 1'b0};
      else if (b == 64)
        exp = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, rd && (n == 256)};
      else
        exp = 6'b001010;
      act = {a_mdc, a_mdio_oe, a_mdio_out, a_busy, a_cmd_ready, a_rd_valid};
      tests++;
      if (act !== exp) begin
        fails++;
        $display("FAIL %s cycle %0d {mdc,oe,out,busy,ready,rd_valid} got %b want %b",
                 tag, n, act, exp);
      end
      if (rd && b == 46)                 a_mdio_in = 1'b1;
      else if (rd && b == 47)            a_mdio_in = ta1;
      else if (rd && b >= 48 && b < 64)  a_mdio_in = word[63-b];
      else                               a_mdio_in = 1'b1;
      if (n < 260) tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    tests++;
    if ({a_mdc, a_mdio_out, a_mdio_oe, a_busy, a_cmd_ready, a_rd_valid, a_rd_err, a_cmd_err}
        !== 8'b0100_0000) begin
      fails++;
      $display("FAIL reset_a_ctrl got %b want 01000000",
               {a_mdc, a_mdio_out, a_mdio_oe, a_busy, a_cmd_ready, a_rd_valid, a_rd_err, a_cmd_err});
    end
    tests++;
    if (a_rd_data !== 16'h0000) begin
      fails++; $display("FAIL reset_a_rd_data got %h want 0000", a_rd_data);
    end
    tests++;
    if ({b_mdc, b_mdio_out, b_mdio_oe, b_busy, b_cmd_ready, b_rd_valid, b_rd_err, b_cmd_err}
        !== 8'b0100_0000) begin
      fails++;
      $display("FAIL reset_b_ctrl got %b want 01000000",
               {b_mdc, b_mdio_out, b_mdio_oe, b_busy, b_cmd_ready, b_rd_valid, b_rd_err, b_cmd_err});
    end
    reset = 1'b0;
    tick();
    tests++;
    if ({a_cmd_ready, b_cmd_ready} !== 2'b11) begin
      fails++; $display("FAIL reset_release_ready got %b want 11", {a_cmd_ready, b_cmd_ready});
    end
  endtask

  task automatic test_c22_write();
    issue_a(2'b01, 2'b01, 5'd3, 5'd0, 16'h1140);
    drive_frame_a({32'hFFFF_FFFF, 2'b01, 2'b01, 5'b00011, 5'b00000, 2'b10, 16'h1140},
                  64, 1'b0, 1'b0, 16'h0000, "c22_wr");
    tests++;
    if ({a_rd_err, a_rd_data} !== 17'h0_0000) begin
      fails++; $display("FAIL c22_wr_rd_untouched got %b/%h want 0/0000", a_rd_err, a_rd_data);
    end
  endtask

  task automatic test_c22_read();
    issue_a(2'b01, 2'b10, 5'd1, 5'd2, 16'h0000);
    drive_frame_a({32'hFFFF_FFFF, 2'b01, 2'b10, 5'b00001, 5'b00010, 18'h3FFFF},
                  46, 1'b1, 1'b0, 16'h0141, "c22_rd");
    tests++;
    if (a_rd_data !== 16'h0141) begin
      fails++; $display("FAIL c22_rd_data got %h want 0141", a_rd_data);
    end
    tests++;
    if (a_rd_err !== 1'b0) begin
      fails++; $display("FAIL c22_rd_err got %b want 0", a_rd_err);
    end
  endtask

  task automatic test_no_phy();
    issue_a(2'b01, 2'b10, 5'd7, 5'd1, 16'h0000);
    drive_frame_a({32'hFFFF_FFFF, 2'b01, 2'b10, 5'b00111, 5'b00001, 18'h3FFFF},
                  46, 1'b1, 1'b1, 16'hFFFF, "no_phy");
    tests++;
    if (a_rd_data !== 16'hFFFF) begin
      fails++; $display("FAIL no_phy_data got %h want ffff", a_rd_data);
    end
    tests++;
    if (a_rd_err !== 1'b1) begin
      fails++; $display("FAIL no_phy_err got %b want 1", a_rd_err);
    end
  endtask

  task automatic test_illegal();
    logic [1:0] bad_st [2] = '{2'b01, 2'b10};
    logic [1:0] bad_op [2] = '{2'b11, 2'b01};
    for (int i = 0; i < 2; i++) begin
      a_cmd_valid = 1'b1; a_cmd_st = bad_st[i]; a_cmd_op = bad_op[i];
      tick();
      a_cmd_valid = 1'b0;
      tests++;
      if ({a_cmd_err, a_cmd_ready, a_mdc, a_busy, a_mdio_oe} !== 5'b10000) begin
        fails++;
        $display("FAIL illegal%0d_pulse {err,ready,mdc,busy,oe} got %b want 10000",
                 i, {a_cmd_err, a_cmd_ready, a_mdc, a_busy, a_mdio_oe});
      end
      tick();
      tests++;
      if ({a_cmd_err, a_cmd_ready, a_mdc, a_busy} !== 4'b0100) begin
        fails++;
        $display("FAIL illegal%0d_after {err,ready,mdc,busy} got %b want 0100",
                 i, {a_cmd_err, a_cmd_ready, a_mdc, a_busy});
      end
    end
    issue_a(2'b01, 2'b01, 5'd4, 5'd9, 16'hA5C3);
    drive_frame_a({32'hFFFF_FFFF, 2'b01, 2'b01, 5'b00100, 5'b01001, 2'b10, 16'hA5C3},
                  64, 1'b0, 1'b0, 16'h0000, "post_illegal_wr");
    tests++;
    if ({a_rd_err, a_rd_data} !== 17'h1_FFFF) begin
      fails++; $display("FAIL wr_keeps_rd got %b/%h want 1/ffff", a_rd_err, a_rd_data);
    end
  endtask

  task automatic test_reset_mid_frame();
    issue_a(2'b01, 2'b01, 5'd3, 5'd0, 16'h1140);
    for (int i = 0; i < 80; i++) tick();
    reset = 1'b1;
    tick();
    tests++;
    if ({a_mdio_oe, a_mdc, a_busy, a_cmd_ready, a_rd_valid, a_mdio_out} !== 6'b000001) begin
      fails++;
      $display("FAIL mid_reset {oe,mdc,busy,ready,rd_valid,out} got %b want 000001",
               {a_mdio_oe, a_mdc, a_busy, a_cmd_ready, a_rd_valid, a_mdio_out});
    end
    tests++;
    if ({a_rd_err, a_rd_data} !== 17'h0_0000) begin
      fails++; $display("FAIL mid_reset_rd got %b/%h want 0/0000", a_rd_err, a_rd_data);
    end
    reset = 1'b0;
    tick();
    tests++;
    if (a_cmd_ready !== 1'b1) begin
      fails++; $display("FAIL mid_reset_ready got %b want 1", a_cmd_ready);
    end
    issue_a(2'b01, 2'b10, 5'd1, 5'd2, 16'h0000);
    drive_frame_a({32'hFFFF_FFFF, 2'b01, 2'b10, 5'b00001, 5'b00010, 18'h3FFFF},
                  46, 1'b1, 1'b0, 16'h0141, "post_reset_rd");
    tests++;
    if ({a_rd_err, a_rd_data} !== 17'h0_0141) begin
      fails++; $display("FAIL post_reset_rd got %b/%h want 0/0141", a_rd_err, a_rd_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] line_addr = {2'b00, 2'b00, 5'd5, 5'd1, 2'b10, 16'h1234};
    logic [31:0] line_rd   = {2'b00, 2'b11, 5'd5, 5'd1, 18'h3FFFF};
    logic [15:0] word      = 16'hBEEF;
    b_cmd_valid = 1'b1; b_cmd_st = 2'b00; b_cmd_op = 2'b00;
    b_cmd_phyad = 5'd5; b_cmd_regad = 5'd1; b_cmd_wdata = 16'h1234;
    tick();
    b_cmd_op = 2'b11; b_cmd_wdata = 16'h0000;
    for (int n = 0; n <= 133; n++) begin
      int m, b;
      logic rd;
      logic [31:0] line;
      logic [5:0] exp, act;
      if (n < 67) begin m = n; line = line_addr; rd = 1'b0; end
      else begin m = n - 67; line = line_rd; rd = 1'b1; end
      if (n == 67) b_cmd_valid = 1'b0;
      b = m / 2;
      if (b < 32)
        exp = {(m % 2) == 1, !(rd && b >= 14), (rd && b >= 14) ? 1'b1 : line[31-b],
               1'b1, 1'b0, 1'b0};
      else if (b == 32)
        exp = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, rd && (m == 64)};
      else
        exp = 6'b001010;
      act = {b_mdc, b_mdio_oe, b_mdio_out, b_busy, b_cmd_ready, b_rd_valid};
      tests++;
      if (act !== exp) begin
        fails++;
        $display("FAIL b2b cycle %0d {mdc,oe,out,busy,ready,rd_valid} got %b want %b",
                 n, act, exp);
      end
      if (rd && b == 15)                 b_mdio_in = 1'b0;
      else if (rd && b >= 16 && b < 32)  b_mdio_in = word[31-b];
      else                               b_mdio_in = 1'b1;
      if (n < 133) tick();
    end
    tests++;
    if ({b_rd_err, b_rd_data} !== 17'h0_BEEF) begin
      fails++; $display("FAIL b2b_rd got %b/%h want 0/beef", b_rd_err, b_rd_data);
    end
  endtask

  initial begin
    test_reset();
    test_c22_write();
    test_c22_read();
    test_no_phy();
    test_illegal();
    test_reset_mid_frame();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
